// File: rtl/park_pkg.sv
// Shared constants for the car-park display: letter codes, display words,
// anode selects and the scan state type.
package park_pkg;

  localparam logic [3:0] LT_L = 4'd0;
  localparam logic [3:0] LT_U = 4'd1;
  localparam logic [3:0] LT_F = 4'd2;
  localparam logic [3:0] LT_O = 4'd3;
  localparam logic [3:0] LT_P = 4'd4;
  localparam logic [3:0] LT_E = 4'd5;
  localparam logic [3:0] LT_N = 4'd6;

  // Words packed {digit3, digit2, digit1, digit0}
  localparam logic [15:0] WORD_FULL = {LT_F, LT_U, LT_L, LT_L};
  localparam logic [15:0] WORD_OPEN = {LT_O, LT_P, LT_E, LT_N};

  // Active-low anode selects
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_D3  = 4'b0111;
  localparam logic [3:0] AN_D2  = 4'b1011;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D0  = 4'b1110;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } scan_state_e;

  function automatic logic [3:0] an_sel(input logic [1:0] digit);
    case (digit)
      2'd3:    return AN_D3;
      2'd2:    return AN_D2;
      2'd1:    return AN_D1;
      default: return AN_D0;
    endcase
  endfunction

  function automatic logic [3:0] word_code(input logic [15:0] word, input logic [1:0] digit);
    return word[{digit, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seven_seg.sv
// Combinational letter-code to 7-segment decoder, segments {a..g}, active-low.
module seven_seg
  import park_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Map each letter code to its segment pattern; unused codes blank
  always_comb begin
    seg = SEG_OFF;
    case (code)
      LT_L:    seg = 7'b1110001;
      LT_U:    seg = 7'b1000001;
      LT_F:    seg = 7'b0111000;
      LT_O:    seg = 7'b0000001;
      LT_P:    seg = 7'b0011000;
      LT_E:    seg = 7'b0110000;
      LT_N:    seg = 7'b1101010;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/park_display_ctrl.sv
// Car-park occupancy counter with a 4-digit multiplexed "OPEn"/"FULL" display.
module park_display_ctrl
  import park_pkg::*;
#(
  parameter  int CAPACITY    = 8,
  parameter  int REFRESH_DIV = 100000,
  localparam int CNT_W       = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             car_in,
  input  logic             car_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             reject,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  localparam int               TW     = $clog2(REFRESH_DIV);
  localparam logic [TW-1:0]    T_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CAP    = CNT_W'(CAPACITY);

  logic in_s1, in_s2, in_prev;
  logic out_s1, out_s2, out_prev;
  logic ev_in, ev_out;

  logic [CNT_W-1:0] count_d;
  logic             reject_d;

  scan_state_e state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [1:0]    digit, digit_d;
  logic [15:0]   word, word_d;
  logic [3:0]    code;
  logic [6:0]    seg_dec;

  // Two-flop synchronisers plus delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_s1    <= 1'b0;
      in_s2    <= 1'b0;
      in_prev  <= 1'b0;
      out_s1   <= 1'b0;
      out_s2   <= 1'b0;
      out_prev <= 1'b0;
    end else begin
      in_s1    <= car_in;
      in_s2    <= in_s1;
      in_prev  <= in_s2;
      out_s1   <= car_out;
      out_s2   <= out_s1;
      out_prev <= out_s2;
    end
  end

  assign ev_in  = in_s2 & ~in_prev;
  assign ev_out = out_s2 & ~out_prev;

  // Occupancy update rules; simultaneous entry and exit cancel out
  always_comb begin
    count_d  = count;
    reject_d = 1'b0;
    case ({ev_in, ev_out})
      2'b10: begin
        if (count != CAP) count_d = count + 1'b1;
        else              reject_d = 1'b1;
      end
      2'b01: begin
        if (count != '0) count_d = count - 1'b1;
        else             reject_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Occupancy registers; full tracks the registered count in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      full   <= 1'b0;
      reject <= 1'b0;
    end else begin
      count  <= count_d;
      full   <= (count_d == CAP);
      reject <= reject_d;
    end
  end

  // Scan sequencing: one BLANK cycle then DRIVE until the slot timer wraps
  always_comb begin
    state_d = state;
    timer_d = timer;
    digit_d = digit;
    word_d  = word;
    case (state)
      ST_BLANK: begin
        state_d = ST_DRIVE;
        timer_d = timer + 1'b1;
      end
      ST_DRIVE: begin
        if (timer == T_LAST) begin
          state_d = ST_BLANK;
          timer_d = '0;
          digit_d = digit - 2'd1;
          // Word only changes as the scan wraps back to digit 3
          if (digit == 2'd0) word_d = full ? WORD_FULL : WORD_OPEN;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Scan state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      timer <= '0;
      digit <= 2'd3;
      word  <= WORD_OPEN;
    end else begin
      state <= state_d;
      timer <= timer_d;
      digit <= digit_d;
      word  <= word_d;
    end
  end

  assign code = word_code(word_d, digit_d);

  seven_seg u_seven_seg (
    .code (code),
    .seg  (seg_dec)
  );

  // Outputs are registered from the next-state values so an/seg line up with
  // the scan state of the same cycle and switch together on one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= (state_d == ST_DRIVE) ? an_sel(digit_d) : AN_OFF;
      seg <= (state_d == ST_DRIVE) ? seg_dec : SEG_OFF;
    end
  end

endmodule
